// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// logic_unit_pipe : pipelined, op-selectable bitwise logic unit with
//                   valid/ready handshakes, zero flag and result counter.
// Rev 1.0
// ============================================================================
module logic_unit_pipe #(
  parameter int WIDTH   = 4,
  parameter int STAGES  = 2,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   in_a_i,
  input  logic [WIDTH-1:0]   in_b_i,
  input  logic [2:0]         in_op_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   out_y_o,
  output logic               out_zero_o,
  output logic [COUNT_W-1:0] out_count_o
);

  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;

  logic [STAGES-1:0]  v_q;
  logic [STAGES-1:0]  z_q;
  logic [WIDTH-1:0]   y_q [STAGES];
  logic [STAGES-1:0]  adv;
  logic [WIDTH-1:0]   res_d;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  logic               out_fire;

  always_comb begin
    res_d = in_a_i;
    case (in_op_i)
      OP_NOT:  res_d = ~in_a_i;
      OP_AND:  res_d = in_a_i & in_b_i;
      OP_OR:   res_d = in_a_i | in_b_i;
      OP_XOR:  res_d = in_a_i ^ in_b_i;
      OP_NAND: res_d = ~(in_a_i & in_b_i);
      OP_NOR:  res_d = ~(in_a_i | in_b_i);
      OP_XNOR: res_d = ~(in_a_i ^ in_b_i);
      default: res_d = in_a_i;
    endcase
  end

  // A stage may load when it is empty or anything downstream can move; the
  // accumulator form avoids a combinational self-loop through adv.
  always_comb begin : adv_chain
    logic acc;
    acc = out_ready_i;
    adv = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc    = acc | ~v_q[i];
      adv[i] = acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      z_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        y_q[i] <= '0;
      end
    end else begin
      if (adv[0]) begin
        v_q[0] <= in_valid_i;
        y_q[0] <= res_d;
        z_q[0] <= (res_d == '0);
      end
      for (int i = 1; i < STAGES; i++) begin
        if (adv[i]) begin
          v_q[i] <= v_q[i-1];
          y_q[i] <= y_q[i-1];
          z_q[i] <= z_q[i-1];
        end
      end
    end
  end

  assign out_fire = v_q[STAGES-1] & out_ready_i;

  always_comb begin
    count_d = count_q;
    if (out_fire) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign in_ready_o  = adv[0];
  assign out_valid_o = v_q[STAGES-1];
  assign out_y_o     = y_q[STAGES-1];
  assign out_zero_o  = z_q[STAGES-1];
  assign out_count_o = count_q;

endmodule
`default_nettype wire
